// File: rtl/bcd_seg_scan_if.sv
// bcd_seg_scan_if: connects the mod-24 BCD hour counter to the display scanner.
//   Q   [7:0] BCD value: [7:4] is tens, [3:0] is units.
//   Co        carry from the counter; pulses high for one cycle on wrap.
//   SEG [6:0] segments {g,f,e,d,c,b,a}, active-low.
//   DIG [1:0] digit enables, active-low: 2'b10 units, 2'b01 tens, 2'b11 none.
//   DP        decimal point, active-low.
// master: the counter/board side. slave: the scanner.
interface bcd_seg_scan_if;
  logic [7:0] Q;
  logic       Co;
  logic [6:0] SEG;
  logic [1:0] DIG;
  logic       DP;

  modport master (output Q, Co, input SEG, DIG, DP);
  modport slave  (input Q, Co, output SEG, DIG, DP);
endinterface

// File: rtl/bcd_seg_scan.sv
// bcd_seg_scan: time-multiplexes the two digits of a BCD hour count onto
// two common-anode 7-segment digits. The units decimal point flashes for
// DP_HOLD units slots after each counter wrap.
//   CLK  rising-edge clock
//   CLR  asynchronous active-high reset
//   bus  bcd_seg_scan_if.slave (Q, Co in; SEG, DIG, DP out, all registered)
// Parameters: DIV (cycles per digit slot, >= 2), DP_HOLD (1..255).
// Build option: define LEADING_ZERO_BLANK_EN to blank a zero tens digit.
module bcd_seg_scan #(
  parameter int DIV     = 50000,
  parameter int DP_HOLD = 4
) (
  input  logic          CLK,
  input  logic          CLR,
  bcd_seg_scan_if.slave bus
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, LO, HI} state_t;

  function automatic logic [6:0] dec(input logic [3:0] d);
    case (d)
      4'd0:    dec = 7'h40;
      4'd1:    dec = 7'h79;
      4'd2:    dec = 7'h24;
      4'd3:    dec = 7'h30;
      4'd4:    dec = 7'h19;
      4'd5:    dec = 7'h12;
      4'd6:    dec = 7'h02;
      4'd7:    dec = 7'h78;
      4'd8:    dec = 7'h00;
      4'd9:    dec = 7'h10;
      default: dec = 7'h3F; // illegal BCD shows a dash
    endcase
  endfunction

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  state_t        state_q, state_d;
  logic [7:0]    shadow_q, shadow_d;
  logic [7:0]    dp_cnt_q, dp_cnt_d;
  logic          co_q;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    dig_q, dig_d;
  logic          dp_q, dp_d;

  logic       tick, co_rise, lo2hi;
  logic [6:0] tens_seg;

  assign tick    = (div_cnt_q == DW'(DIV - 1));
  assign co_rise = bus.Co & ~co_q;

`ifdef LEADING_ZERO_BLANK_EN
  assign tens_seg = (shadow_q[7:4] == 4'd0) ? 7'h7F : dec(shadow_q[7:4]);
`else
  assign tens_seg = dec(shadow_q[7:4]);
`endif

  always_comb begin
    div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);
    state_d   = state_q;
    shadow_d  = shadow_q;
    seg_d     = seg_q;
    dig_d     = dig_q;
    dp_cnt_d  = dp_cnt_q;
    lo2hi     = 1'b0;

    if (tick) begin
      case (state_q)
        // Frame start: latch Q once so the tens slot shows the same sample
        // as the units slot; units come straight from Q on this edge.
        IDLE, HI: begin
          state_d  = LO;
          shadow_d = bus.Q;
          seg_d    = dec(bus.Q[3:0]);
          dig_d    = 2'b10;
        end
        LO: begin
          state_d = HI;
          lo2hi   = 1'b1;
          seg_d   = tens_seg;
          dig_d   = 2'b01;
        end
        default: begin
          state_d = IDLE;
          seg_d   = 7'h7F;
          dig_d   = 2'b11;
        end
      endcase
    end

    // A fresh carry edge takes priority over the per-frame decrement.
    if (co_rise)
      dp_cnt_d = 8'(DP_HOLD);
    else if (lo2hi && dp_cnt_q != 8'd0)
      dp_cnt_d = dp_cnt_q - 8'd1;

    dp_d = ~((state_d == LO) && (dp_cnt_d != 8'd0));
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      div_cnt_q <= '0;
      state_q   <= IDLE;
      shadow_q  <= '0;
      dp_cnt_q  <= '0;
      co_q      <= 1'b0;
      seg_q     <= 7'h7F;
      dig_q     <= 2'b11;
      dp_q      <= 1'b1;
    end else begin
      div_cnt_q <= div_cnt_d;
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      dp_cnt_q  <= dp_cnt_d;
      co_q      <= bus.Co;
      seg_q     <= seg_d;
      dig_q     <= dig_d;
      dp_q      <= dp_d;
    end
  end

  assign bus.SEG = seg_q;
  assign bus.DIG = dig_q;
  assign bus.DP  = dp_q;

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Randomized bench for bcd_seg_scan with DIV=4, DP_HOLD=2. The reference
// model tracks edges since reset release and derives the slot, frame start
// and units->tens boundaries arithmetically; the display is checked every cycle.
module tb_bcd_seg_scan;
  localparam int DIV     = 4;
  localparam int DP_HOLD = 2;

  logic clk = 1'b0;
  logic clr = 1'b1;
  always #5 clk = ~clk;

  bcd_seg_scan_if bus ();

  bcd_seg_scan #(.DIV(DIV), .DP_HOLD(DP_HOLD)) dut (
    .CLK (clk),
    .CLR (clr),
    .bus (bus)
  );

  int n_chk = 0;
  int n_err = 0;

  // reference state
  int         m_n;
  logic [7:0] m_sh;
  int         m_dp;
  bit         m_co;
  logic [6:0] seg_tab [16];

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_sh = '0; m_dp = 0; m_co = 1'b0;
  endtask

  task automatic model_edge(input logic [7:0] q, input logic co);
    int  pos;
    bit  fs, l2h;
    m_n++;
    fs = 0; l2h = 0;
    if (m_n >= DIV) begin
      pos = (m_n - DIV) % (2 * DIV);
      fs  = (pos == 0);
      l2h = (pos == DIV);
    end
    if (fs) m_sh = q;
    if (co && !m_co) m_dp = DP_HOLD;
    else if (l2h && m_dp > 0) m_dp--;
    m_co = co;
  endtask

  task automatic compare();
    logic [6:0] e_seg;
    logic [1:0] e_dig;
    logic       e_dp;
    if (m_n < DIV) begin
      e_seg = 7'h7F; e_dig = 2'b11; e_dp = 1'b1;
    end else if ((((m_n - DIV) / DIV) % 2) == 0) begin
      e_seg = seg_tab[m_sh[3:0]]; e_dig = 2'b10; e_dp = (m_dp != 0) ? 1'b0 : 1'b1;
    end else begin
      e_seg = seg_tab[m_sh[7:4]];
`ifdef LEADING_ZERO_BLANK_EN
      if (m_sh[7:4] == 4'd0) e_seg = 7'h7F;
`endif
      e_dig = 2'b01; e_dp = 1'b1;
    end
    chk("seg", {1'b0, bus.SEG}, {1'b0, e_seg});
    chk("dig", {6'd0, bus.DIG}, {6'd0, e_dig});
    chk("dp",  {7'd0, bus.DP},  {7'd0, e_dp});
  endtask

  // entered just after a falling edge, leaves just after the next one
  task automatic step(input logic [7:0] q, input logic co);
    bus.Q  = q;
    bus.Co = co;
    @(posedge clk);
    model_edge(q, co);
    #1;
    compare();
    @(negedge clk);
  endtask

  task automatic pulse_reset(input int cyc);
    clr = 1'b1;
    #1;
    model_reset();
    compare();
    repeat (cyc) @(negedge clk);
    compare();
    clr = 1'b0;
  endtask

  function automatic logic [3:0] rnd_nib();
    if ($urandom_range(0, 7) == 0) return 4'($urandom_range(10, 15));
    return 4'($urandom_range(0, 9));
  endfunction

  initial begin
    logic [7:0] q;
    int         co_hold;
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
    bus.Q  = 8'h00;
    bus.Co = 1'b0;
    model_reset();
    @(negedge clk);
    #1;
    compare();
    @(negedge clk);
    clr = 1'b0;

    // steady scan, then a mid-frame change, then illegal units / zero tens
    repeat (20) step(8'h23, 1'b0);
    repeat (2)  step(8'h23, 1'b0);
    repeat (16) step(8'h00, 1'b0);
    repeat (16) step(8'h0A, 1'b0);

    // carry pulse in a tens slot, then a second pulse a slot later
    while (!(m_n >= DIV && (((m_n - DIV) / DIV) % 2) == 1)) step(8'h23, 1'b0);
    step(8'h23, 1'b1);
    repeat (5) step(8'h23, 1'b0);
    step(8'h23, 1'b1);
    repeat (30) step(8'h23, 1'b0);

    // reset while the decimal point is armed
    step(8'h17, 1'b1);
    repeat (3) step(8'h17, 1'b0);
    pulse_reset(2);
    repeat (24) step(8'h17, 1'b0);

    // random traffic with carry bursts and occasional resets
    q = 8'h12;
    co_hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) q = {rnd_nib(), rnd_nib()};
      if (co_hold == 0 && $urandom_range(0, 15) == 0) co_hold = $urandom_range(1, 3);
      step(q, co_hold != 0);
      if (co_hold != 0) co_hold--;
      if ($urandom_range(0, 299) == 0) pulse_reset($urandom_range(1, 3));
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/bcd_seg_scan.md
Name: bcd_seg_scan

Overview:
- Downstream display stage for the two-digit BCD mod-24 hour counter.
- Takes the counter's 8-bit BCD value Q and its carry Co, and time-multiplexes two common-anode 7-segment digits.
- Units digit decimal point flashes after each counter wrap (Co pulse).
- Sits between the counter and the board's segment/digit pins.

Parameters:
- DIV, 50000, CLK cycles per digit slot (refresh tick period); legal range ≥ 2.
- DP_HOLD, 4, number of units-digit slots the decimal point stays lit after a Co pulse; legal range 1..255.

Ports:
- CLK  in  1  system clock, rising-edge.
- CLR  in  1  asynchronous, active-high reset.
- Q    in  8  BCD value from the counter: [7:4] tens, [3:0] units.
- Co   in  1  counter carry; a one-cycle high pulse on wrap.
- SEG  out 7  segments {g,f,e,d,c,b,a}, active-low, registered.
- DIG  out 2  digit enables, active-low, registered: 2'b10 = units, 2'b01 = tens, 2'b11 = none.
- DP   out 1  decimal point, active-low, registered.

Behaviour:
- Reset (CLR high, asynchronous, any time including mid-scan):
  - SEG=7'h7F, DIG=2'b11, DP=1.
  - State IDLE; divider, shadow, dp_cnt and Co history all 0.
- Divider: div_cnt counts 0..DIV-1 and wraps to 0. tick=1 in the cycle where div_cnt==DIV-1.
- FSM states: IDLE, LO (units), HI (tens). Transitions occur only on tick:
  - IDLE->LO: frame start.
  - LO->HI.
  - HI->LO: frame start.
- Frame start edge: shadow<=Q. That same edge drives SEG from Q[3:0].
- Q changes mid-frame have no visible effect until the next frame start, so no tearing.
- Output timing: SEG/DIG/DP are registered on the same edge as the state change. DIG and SEG therefore never disagree for a cycle.
  - LO: DIG=2'b10, SEG=dec(units).
  - HI: DIG=2'b01, SEG=dec(tens).
- dec() mapping, active-low:
  - 0→7'h40, 1→7'h79, 2→7'h24, 3→7'h30, 4→7'h19
  - 5→7'h12, 6→7'h02, 7→7'h78, 8→7'h00, 9→7'h10
  - 10..15 (illegal BCD)→7'h3F (dash).
- Co handling:
  - co_d registers Co. A rising edge (Co & ~co_d) loads dp_cnt<=DP_HOLD.
  - On each LO->HI transition, dp_cnt decrements if nonzero.
  - A rising edge in the same cycle as LO->HI: the load wins.
  - A rising edge while dp_cnt is nonzero reloads to DP_HOLD.
  - Co held high for several cycles counts as one event.
- DP=0 only when the next state is LO and the next dp_cnt≠0; otherwise DP=1.
- Width rules:
  - div_cnt is $clog2(DIV) bits.
  - dp_cnt is 8 bits.
  - No arithmetic on Q; it is pure decode.

Optional Feature:
- Macro: LEADING_ZERO_BLANK_EN.
- Defined: in HI, if shadow[7:4]==0, SEG=7'h7F (blank); DIG is still 2'b01.
- Undefined: tens 0 displays 7'h40.
- The units digit is never blanked in either build.

Test Plan (DIV=4, DP_HOLD=2, macro undefined unless stated):
1. Reset release:
   - CLR high → SEG=7'h7F, DIG=2'b11, DP=1.
   - CLR low → outputs unchanged for 3 cycles; on the 4th edge DIG=2'b10.
2. Steady scan, Q=8'h23:
   - LO slot: DIG=2'b10, SEG=7'h30 for 4 cycles.
   - HI slot: DIG=2'b01, SEG=7'h24 for 4 cycles.
   - The pattern repeats.
3. Mid-frame change, Q 8'h23→8'h00 during HI:
   - SEG stays 7'h24 until the slot ends.
   - Next LO shows 7'h40; next HI shows 7'h40.
4. Illegal BCD and blanking, Q=8'h0A:
   - LO: SEG=7'h3F; HI: SEG=7'h40.
   - With LEADING_ZERO_BLANK_EN, HI: SEG=7'h7F with DIG=2'b01.
5. Decimal point, one-cycle Co pulse during HI:
   - DP=0 for exactly the next two LO slots, DP=1 during HI slots and afterwards.
   - A second pulse during the first lit LO slot extends this to two LO slots after the reload.
6. Reset mid-operation, CLR pulse during HI while dp_cnt≠0:
   - Immediate SEG=7'h7F, DIG=2'b11, DP=1.
   - After release, DP stays 1 and the scan restarts at LO after 4 cycles.
